// File: rtl/time_of_day_counter.sv
// time_of_day_counter: hh:mm:ss counter advanced by a 1 Hz enable strobe, with a handshaked, range-checked time set.
// Define ALARM_EN to build the hour:minute alarm comparator; otherwise alarm_* inputs are ignored and alarm_hit is 0.
module time_of_day_counter #(
    parameter int HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       run_en,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    output logic       set_done,
    output logic       set_err,
    input  logic       alarm_wr,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    output logic       alarm_hit,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       day_wrap
);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] CHECK = 1'b1;
    localparam logic [4:0] HMAX  = 5'(HOUR_MAX);

    logic [0:0] r_state;
    logic [4:0] r_hour, r_sh_hour;
    logic [5:0] r_min, r_sec, r_sh_min, r_sh_sec;
    logic       r_set_ready, r_set_done, r_set_err, r_day_wrap, r_alarm_hit;
    logic       w_cnt, w_accept, w_set_ok, w_load, w_adv, w_match;
    logic       w_sec_wrap, w_min_wrap, w_hour_wrap;
    logic [4:0] w_hour_nx;
    logic [5:0] w_min_nx, w_sec_nx;

    assign w_cnt       = tick_1hz & run_en;
    assign w_accept    = (r_state == RUN) & set_valid;
    assign w_set_ok    = (r_sh_hour <= HMAX) && (r_sh_min <= 6'd59) && (r_sh_sec <= 6'd59);
    assign w_load      = (r_state == CHECK) & w_set_ok;
    // A passing load overrides a tick arriving in the same cycle.
    assign w_adv       = w_cnt & ~w_load;

    assign w_sec_wrap  = r_sec == 6'd59;
    assign w_min_wrap  = w_sec_wrap & (r_min == 6'd59);
    assign w_hour_wrap = w_min_wrap & (r_hour == HMAX);
    assign w_sec_nx    = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
    assign w_min_nx    = w_sec_wrap ? (w_min_wrap ? 6'd0 : r_min + 6'd1) : r_min;
    assign w_hour_nx   = w_min_wrap ? (w_hour_wrap ? 5'd0 : r_hour + 5'd1) : r_hour;

`ifdef ALARM_EN
    logic [4:0] r_al_hour;
    logic [5:0] r_al_min;
    logic       r_al_armed, w_al_ok;

    assign w_al_ok = (alarm_hour <= HMAX) && (alarm_min <= 6'd59);
    // Compares against the stored alarm, so a same-cycle write affects only later matches.
    assign w_match = r_al_armed && (w_hour_nx == r_al_hour) && (w_min_nx == r_al_min) && (w_sec_nx == 6'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_al_hour  <= 5'd0;
            r_al_min   <= 6'd0;
            r_al_armed <= 1'b0;
        end else if (alarm_wr && w_al_ok) begin
            r_al_hour  <= alarm_hour;
            r_al_min   <= alarm_min;
            r_al_armed <= 1'b1;
        end
    end
`else
    logic w_unused_alarm;

    assign w_unused_alarm = ^{alarm_wr, alarm_hour, alarm_min};
    assign w_match        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_hour      <= 5'd0;
            r_min       <= 6'd0;
            r_sec       <= 6'd0;
            r_sh_hour   <= 5'd0;
            r_sh_min    <= 6'd0;
            r_sh_sec    <= 6'd0;
            r_set_ready <= 1'b1;
            r_set_done  <= 1'b0;
            r_set_err   <= 1'b0;
            r_day_wrap  <= 1'b0;
            r_alarm_hit <= 1'b0;
        end else begin
            r_state     <= w_accept ? CHECK : RUN;
            r_set_ready <= ~w_accept;
            r_set_done  <= w_load;
            r_set_err   <= (r_state == CHECK) & ~w_set_ok;
            r_day_wrap  <= w_adv & w_hour_wrap;
            r_alarm_hit <= w_adv & w_match;
            if (w_load) begin
                r_hour <= r_sh_hour;
                r_min  <= r_sh_min;
                r_sec  <= r_sh_sec;
            end else if (w_cnt) begin
                r_hour <= w_hour_nx;
                r_min  <= w_min_nx;
                r_sec  <= w_sec_nx;
            end
            if (w_accept) begin
                r_sh_hour <= set_hour;
                r_sh_min  <= set_min;
                r_sh_sec  <= set_sec;
            end
        end
    end

    assign set_ready = r_set_ready;
    assign set_done  = r_set_done;
    assign set_err   = r_set_err;
    assign day_wrap  = r_day_wrap;
    assign alarm_hit = r_alarm_hit;
    assign hour      = r_hour;
    assign min       = r_min;
    assign sec       = r_sec;
endmodule
